// File: rtl/mul_64_pkg.sv
// Shared definitions for the position-arithmetic units (multiplier and divider).
// Holds the FSM state encoding, default operand geometry and Q32.32 constants.
// No logic of its own.
package mul_64_pkg;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_FRAC  = 32;

    // Q32.32 representation of 1.0, shared with the divider
    localparam logic [63:0] ONE = 64'(1) << 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul_64_if.sv
// Start/busy/done handshake bundle between the motion controller and mul_64.
// Pure wiring, no latency.
// No backpressure: the controller must wait for busy low before a new start.
interface mul_64_if
    import mul_64_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             init_in;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Result;
    logic             busy;
    logic             done;

    modport master (output init_in, A, B, input Result, busy, done);
    modport slave  (input init_in, A, B, output Result, busy, done);
endinterface

// File: rtl/mul_64_step.sv
// One shift-add iteration: conditionally add mcand into the upper half, then shift right.
// Purely combinational, zero latency.
// No handshake; the caller sequences iterations.
module mul_step #(
    parameter int WIDTH = 64
) (
    input  logic [2*WIDTH-1:0] i_prod,
    input  logic [WIDTH-1:0]   i_mcand,
    input  logic               i_mplr_bit,
    output logic [2*WIDTH-1:0] o_prod
);

    logic [WIDTH:0] w_sum;

    // Add with the carry kept, then shift the whole product right with the carry entering the MSB
    always_comb begin
        w_sum  = {1'b0, i_prod[2*WIDTH-1:WIDTH]} + {1'b0, (i_mcand & {WIDTH{i_mplr_bit}})};
        o_prod = (2*WIDTH)'({w_sum, i_prod[WIDTH-1:0]} >> 1);
    end

endmodule

// File: rtl/mul_64.sv
// Sequential unsigned fixed-point multiplier, Result = (A*B) >> FRAC, one multiplier bit per clock.
// Latency: start edge k -> Result/done after edge k+WIDTH+1; busy high WIDTH+1 cycles.
// Starts arriving while busy are dropped; MUL64_SATURATE_EN clamps overflowed results to all ones.
module mul_64
    import mul_64_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = DEF_FRAC
) (
    input logic       clk,
    input logic       rst,
    mul_64_if.slave   bus
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_init_q;
    logic               w_start;
    logic [2*WIDTH-1:0] r_prod;
    logic [2*WIDTH-1:0] w_prod_nxt;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplr;
    logic [WIDTH-1:0]   r_result;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               r_done;

    assign w_start    = bus.init_in & ~r_init_q;
    assign bus.Result = r_result;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;

`ifdef MUL64_SATURATE_EN
    logic w_ovf;
    assign w_ovf = |(r_prod >> (FRAC + WIDTH));
`endif

    mul_step #(.WIDTH(WIDTH)) u_step (
        .i_prod     (r_prod),
        .i_mcand    (r_mcand),
        .i_mplr_bit (r_mplr[0]),
        .o_prod     (w_prod_nxt)
    );

    // Track init_in every cycle so a held level never retriggers, even across RUN/DONE
    always_ff @(posedge clk) begin
        if (!rst) r_init_q <= 1'b0;
        else      r_init_q <= bus.init_in;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state: start only honoured in IDLE, fixed WIDTH iterations, one DONE cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = RUN;
            RUN:     if (r_cnt == LAST) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath and handshake registers; reset aborts any operation without touching Result afterwards
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplr   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_mcand <= bus.A;
                        r_mplr  <= bus.B;
                        r_prod  <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    r_prod <= w_prod_nxt;
                    r_mplr <= r_mplr >> 1;
                    r_cnt  <= r_cnt + 1'b1;
                end
                DONE: begin
`ifdef MUL64_SATURATE_EN
                    if (w_ovf) r_result <= '1;
                    else       r_result <= r_prod[FRAC +: WIDTH];
`else
                    r_result <= r_prod[FRAC +: WIDTH];
`endif
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_64.sv
module tb_mul_64;
    import mul_64_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul_64_if #(.WIDTH(64)) bus ();

    mul_64 #(.WIDTH(64), .FRAC(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation and watch a fixed window; optionally raise a second start at cycle second_at.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input int hold, input int second_at,
                          output int lat, output int busy_cnt, output int done_cnt, output logic [63:0] res);
        lat = 0; busy_cnt = 0; done_cnt = 0; res = '0;
        bus.A = a; bus.B = b; bus.init_in = 1'b1;
        for (int n = 1; n <= 90; n++) begin
            step();
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (lat == 0) begin
                    lat = n - 1;
                    res = bus.Result;
                end
            end
            if (n == hold) bus.init_in = 1'b0;
            if (n == second_at) begin
                bus.init_in = 1'b1;
                bus.A = 64'h0000_0009_0000_0000;
                bus.B = 64'h0000_0009_0000_0000;
            end
            if (n == second_at + 2) bus.init_in = 1'b0;
        end
        bus.init_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; bus.init_in = 1'b0; bus.A = '0; bus.B = '0;
        repeat (3) step();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        total++; if (bus.Result !== 64'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", bus.Result); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int lat, bc, dc; logic [63:0] res;
        run_op(64'h0000_0002_0000_0000, 64'h0000_0003_0000_0000, 4, -100, lat, bc, dc, res);
        total++; if (res !== 64'h0000_0006_0000_0000) begin bad++; $display("FAIL basic_result got=%h exp=%h", res, 64'h0000_0006_0000_0000); end
        total++; if (lat != 65) begin bad++; $display("FAIL basic_latency got=%0d exp=65", lat); end
        total++; if (bc != 65) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=65", bc); end
        total++; if (dc != 1) begin bad++; $display("FAIL basic_done_pulses got=%0d exp=1", dc); end
        total++; if (bus.Result !== 64'h0000_0006_0000_0000) begin bad++; $display("FAIL basic_hold got=%h exp=%h", bus.Result, 64'h0000_0006_0000_0000); end
    endtask

    task automatic test_big();
        int lat, bc, dc; logic [63:0] res;
        run_op(64'(8835) << 32, 64'd100000000, 1, -100, lat, bc, dc, res);
        total++; if (res !== 64'd883500000000) begin bad++; $display("FAIL big_result got=%h exp=%h", res, 64'd883500000000); end
        total++; if (lat != 65) begin bad++; $display("FAIL big_latency got=%0d exp=65", lat); end
    endtask

    task automatic test_zero();
        int lat, bc, dc; logic [63:0] res;
        run_op(64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1, -100, lat, bc, dc, res);
        total++; if (res !== 64'h0) begin bad++; $display("FAIL zero_result got=%h exp=0", res); end
        total++; if (lat != 65) begin bad++; $display("FAIL zero_latency got=%0d exp=65", lat); end
        total++; if (bc != 65) begin bad++; $display("FAIL zero_busy_cycles got=%0d exp=65", bc); end
    endtask

    task automatic test_overflow();
        int lat, bc, dc; logic [63:0] res; logic [63:0] exp_r;
`ifdef MUL64_SATURATE_EN
        exp_r = 64'hFFFF_FFFF_FFFF_FFFF;
`else
        exp_r = 64'h0;
`endif
        run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1, -100, lat, bc, dc, res);
        total++; if (res !== exp_r) begin bad++; $display("FAIL overflow_result got=%h exp=%h", res, exp_r); end
    endtask

    task automatic test_fractions();
        int lat, bc, dc; logic [63:0] res;
        // 1.5 * 0.5 = 0.75
        run_op(64'h0000_0001_8000_0000, 64'h0000_0000_8000_0000, 1, -100, lat, bc, dc, res);
        total++; if (res !== 64'h0000_0000_C000_0000) begin bad++; $display("FAIL frac_result got=%h exp=%h", res, 64'h0000_0000_C000_0000); end
        // 3 ulp * 0.5 = 1.5 ulp, truncated to 1 ulp
        run_op(64'h3, 64'h0000_0000_8000_0000, 1, -100, lat, bc, dc, res);
        total++; if (res !== 64'h1) begin bad++; $display("FAIL trunc_result got=%h exp=1", res); end
    endtask

    task automatic test_reset_in_run();
        int lat, bc, dc, late_done; logic [63:0] res;
        bus.A = 64'h0000_0005_0000_0000; bus.B = 64'h0000_0007_0000_0000; bus.init_in = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            step();
            bus.init_in = 1'b0;
        end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rstrun_busy_before got=%b exp=1", bus.busy); end
        rst = 1'b0;
        step();
        rst = 1'b1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstrun_busy got=%b exp=0", bus.busy); end
        total++; if (bus.Result !== 64'h0) begin bad++; $display("FAIL rstrun_result got=%h exp=0", bus.Result); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rstrun_done got=%b exp=0", bus.done); end
        late_done = 0;
        for (int n = 0; n < 80; n++) begin
            step();
            if (bus.done) late_done++;
        end
        total++; if (late_done != 0) begin bad++; $display("FAIL rstrun_no_done got=%0d exp=0", late_done); end
        run_op(64'h0000_0005_0000_0000, 64'h0000_0007_0000_0000, 1, -100, lat, bc, dc, res);
        total++; if (res !== 64'h0000_0023_0000_0000) begin bad++; $display("FAIL rstrun_restart got=%h exp=%h", res, 64'h0000_0023_0000_0000); end
        total++; if (lat != 65) begin bad++; $display("FAIL rstrun_restart_latency got=%0d exp=65", lat); end
    endtask

    task automatic test_back_to_back();
        int lat, bc, dc; logic [63:0] res;
        run_op(64'h0000_000A_0000_0000, 64'h0000_0004_0000_0000, 1, 20, lat, bc, dc, res);
        total++; if (dc != 1) begin bad++; $display("FAIL b2b_done_pulses got=%0d exp=1", dc); end
        total++; if (res !== 64'h0000_0028_0000_0000) begin bad++; $display("FAIL b2b_result got=%h exp=%h", res, 64'h0000_0028_0000_0000); end
        total++; if (lat != 65) begin bad++; $display("FAIL b2b_latency got=%0d exp=65", lat); end
        total++; if (bus.Result !== 64'h0000_0028_0000_0000) begin bad++; $display("FAIL b2b_hold got=%h exp=%h", bus.Result, 64'h0000_0028_0000_0000); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_big();
        test_zero();
        test_overflow();
        test_fractions();
        test_reset_in_run();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
